// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, state encoding and the angle-table scaling helper.
// The table holds atan(2^-k) in 16-bit binary-angle units (2^16 LSB = 360 degrees).
package cordic_pkg;

    localparam int unsigned KW = 4;

    localparam logic [15:0] ATAN16 [0:15] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    typedef enum logic [1:0] {IDLE, PRE, ROT, DONE} cordic_state_t;

    // Round-to-nearest when narrowing the 16-bit table to ANG_W bits.
    function automatic int atan_scaled(input int k, input int ang_w);
        int sh;
        int a;
        sh = 16 - ang_w;
        a  = int'(ATAN16[k[KW-1:0]]);
        if (sh > 0) begin
            a = (a + (1 << (sh - 1))) >> sh;
        end
        return a;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y towards zero and
// accumulates the rotated angle into z. Reusable in an unrolled pipeline.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int unsigned W     = 10,
    parameter int unsigned ANG_W = 16
) (
    input  logic signed [W-1:0]     x_i,
    input  logic signed [W-1:0]     y_i,
    input  logic signed [ANG_W-1:0] z_i,
    input  logic        [KW-1:0]    k_i,
    output logic signed [W-1:0]     x_o,
    output logic signed [W-1:0]     y_o,
    output logic signed [ANG_W-1:0] z_o
);

    logic signed [W-1:0]     x_sh;
    logic signed [W-1:0]     y_sh;
    logic signed [ANG_W-1:0] atan_k;

    always_comb begin
        x_sh   = x_i >>> k_i;
        y_sh   = y_i >>> k_i;
        atan_k = ANG_W'(atan_scaled(int'(k_i), int'(ANG_W)));
        if (!y_i[W-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_k;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_k;
        end
    end

endmodule

// File: rtl/cordic_vec_param.sv
// Sequential CORDIC vectoring engine: one I/Q sample in, binary-angle phase out.
// Define CORDIC_DPHASE_EN to add the phase-difference (o_dphase) and direction (o_dir) outputs.
module cordic_vec_param
    import cordic_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned ANG_W = 16,
    parameter int unsigned ITER  = 6,
    parameter int unsigned GUARD = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [IN_W-1:0]  i_I,
    input  logic signed [IN_W-1:0]  i_Q,
    output logic                    o_valid,
    output logic signed [ANG_W-1:0] o_angle,
    output logic signed [ANG_W-1:0] o_dphase,
    output logic                    o_dir
);

    localparam int unsigned W = IN_W + 2 + GUARD;
    localparam logic signed [ANG_W-1:0] QUARTER = {2'b01, {(ANG_W-2){1'b0}}};
    localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

    cordic_state_t state_q, state_d;
    logic signed [W-1:0]     x_q, x_d, y_q, y_d;
    logic signed [ANG_W-1:0] z_q, z_d;
    logic        [KW-1:0]    k_q, k_d;
    logic                    zero_q, zero_d;
    logic                    valid_q, valid_d;
    logic signed [ANG_W-1:0] angle_q, angle_d;

    logic signed [W-1:0]     i_ext, q_ext;
    logic signed [W-1:0]     x_rot, y_rot;
    logic signed [ANG_W-1:0] z_rot;

    // Two headroom bits make negating the most-negative sample safe in PRE.
    assign i_ext = {{(W-IN_W){i_I[IN_W-1]}}, i_I} <<< GUARD;
    assign q_ext = {{(W-IN_W){i_Q[IN_W-1]}}, i_Q} <<< GUARD;

    cordic_vec_stage #(
        .W     (W),
        .ANG_W (ANG_W)
    ) u_stage (
        .x_i (x_q),
        .y_i (y_q),
        .z_i (z_q),
        .k_i (k_q),
        .x_o (x_rot),
        .y_o (y_rot),
        .z_o (z_rot)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        angle_d = angle_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = i_ext;
                    y_d     = q_ext;
                    z_d     = '0;
                    k_d     = '0;
                    zero_d  = (i_I == '0) && (i_Q == '0);
                    state_d = PRE;
                end
            end
            PRE: begin
                k_d     = '0;
                state_d = ROT;
                if (!x_q[W-1]) begin
                    z_d = '0;
                end else if (!y_q[W-1]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = QUARTER;
                end else begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -QUARTER;
                end
            end
            ROT: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                // A zero vector has no defined phase; report 0 rather than the accumulated z.
                angle_d = zero_q ? '0 : z_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            angle_q <= angle_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = valid_q;
    assign o_angle = angle_q;

`ifdef CORDIC_DPHASE_EN
    logic signed [ANG_W-1:0] prev_q, prev_d;
    logic signed [ANG_W-1:0] dphase_q, dphase_d;
    logic                    dir_q, dir_d;

    always_comb begin
        prev_d   = prev_q;
        dphase_d = dphase_q;
        dir_d    = dir_q;
        if (state_q == DONE) begin
            dphase_d = angle_d - prev_q;
            prev_d   = angle_d;
            dir_d    = !dphase_d[ANG_W-1] && (dphase_d != '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= '0;
            dphase_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            dphase_q <= dphase_d;
            dir_q    <= dir_d;
        end
    end

    assign o_dphase = dphase_q;
    assign o_dir    = dir_q;
`else
    assign o_dphase = '0;
    assign o_dir    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_vec_param.sv
// Self-checking bench for cordic_vec_param at default parameters: integer CORDIC
// model plus hand-computed literal expectations, checked on every cycle.
module tb_cordic_vec_param;

    localparam int LAT = 9;      // negedge count from driving i_valid to seeing o_valid
    localparam int TOL = 400;
    localparam int ATAN_TB [0:5] = '{8192, 4836, 2555, 1297, 651, 326};

    typedef struct {
        int angle;
        int due;
        int dphase;
        int dir;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic signed [3:0]  i_I = '0;
    logic signed [3:0]  i_Q = '0;
    logic               o_valid;
    logic signed [15:0] o_angle;
    logic signed [15:0] o_dphase;
    logic               o_dir;

    int   nchecks = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   held = 0;
    int   exp_prev = 0;
    exp_t exp_q[$];

    cordic_vec_param dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_I      (i_I),
        .i_Q      (i_Q),
        .o_valid  (o_valid),
        .o_angle  (o_angle),
        .o_dphase (o_dphase),
        .o_dir    (o_dir)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // Plain-integer CORDIC vectoring: quadrant fold, 6 rotations, 4 guard bits.
    function automatic int model_angle(input int i, input int q);
        int x, y, z, xn, yn;
        if (i == 0 && q == 0) return 0;
        x = i * 16;
        y = q * 16;
        z = 0;
        if (i < 0) begin
            if (q >= 0) begin
                x = q * 16;  y = -i * 16; z = 16384;
            end else begin
                x = -q * 16; y = i * 16;  z = -16384;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (y >= 0) begin
                xn = x + (y >>> k); yn = y - (x >>> k); z = z + ATAN_TB[k];
            end else begin
                xn = x - (y >>> k); yn = y + (x >>> k); z = z - ATAN_TB[k];
            end
            x = xn;
            y = yn;
        end
        return wrap16(z);
    endfunction

    task automatic check(input string name, input int got, input int want);
        nchecks++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_near(input string name, input int got, input int want);
        int d;
        d = wrap16(got - want);
        nchecks++;
        if (d > TOL || d < -TOL) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, got, want, TOL);
        end
    endtask

    // Compare process: every cycle out of reset, outputs against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (reset_n) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency_cycle", cyc, e.due);
                    check("angle_exact", int'(o_angle), e.angle);
                    check("dphase", int'(o_dphase), e.dphase);
                    check("dir", int'(o_dir), e.dir);
                    held = e.angle;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("missing_valid", 0, 1);
                void'(exp_q.pop_front());
            end
            check("angle_hold", int'(o_angle), held);
        end
    end

    task automatic send(input int i, input int q, output int acc);
        exp_t e;
        int   n;
        @(negedge clock);
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", int'(o_ready), 1);
        i_valid = 1'b1;
        i_I     = 4'(i);
        i_Q     = 4'(q);
        e.angle = model_angle(i, q);
        e.due   = cyc + LAT;
`ifdef CORDIC_DPHASE_EN
        e.dphase = wrap16(e.angle - exp_prev);
        e.dir    = (e.dphase > 0) ? 1 : 0;
        exp_prev = e.angle;
`else
        e.dphase = 0;
        e.dir    = 0;
`endif
        exp_q.push_back(e);
        acc = cyc + 1;
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    int vi [0:10] = '{7, 0,      0,      -8,     5,    -5,     -5,    0,     -5,     -5,     0};
    int vq [0:10] = '{0, 7,      -8,     0,      5,    -5,     5,     7,     -5,     -5,     7};
    int va [0:10] = '{0, 16384, -16384, -32768, 8192, -24576, 24576, 16384, -24576, -24576, 16384};

    initial begin
        int acc, acc2;

        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_angle", int'(o_angle), 0);
        check("rst_dphase", int'(o_dphase), 0);
        check("rst_dir", int'(o_dir), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", int'(o_ready), 1);

        check("model_pin_7_0", model_angle(7, 0), -171);
        check("model_pin_5_5", model_angle(5, 5), 8199);
        check("model_pin_zero", model_angle(0, 0), 0);

        // Quadrants, diagonals, then the (0,7)->(-5,-5)->(-5,-5)->(0,7) phase-step sequence.
        for (int n = 0; n <= 10; n++) begin
            send(vi[n], vq[n], acc);
            wait_done();
            check_near($sformatf("approx_%0d_%0d", vi[n], vq[n]), int'(o_angle), va[n]);
`ifdef CORDIC_DPHASE_EN
            if (n == 8) begin
                check_near("dphase_ccw", int'(o_dphase), 24576);
                check("dir_ccw", int'(o_dir), 1);
            end
            if (n == 10) begin
                check_near("dphase_cw", int'(o_dphase), -24576);
                check("dir_cw", int'(o_dir), 0);
            end
`endif
        end

        // Handshake: busy-time i_valid must be ignored.
        send(3, 3, acc);
        check("ready_low_busy", int'(o_ready), 0);
        i_valid = 1'b1;
        i_I     = -4'sd8;
        i_Q     = 4'sd0;
        repeat (2) @(negedge clock);
        i_valid = 1'b0;
        wait_done();
        check_near("approx_3_3", int'(o_angle), 8192);

        // Back-to-back throughput.
        send(2, -7, acc);
        send(-3, 1, acc2);
        check("throughput", acc2 - acc, 9);
        wait_done();

        // Reset four cycles after accept aborts without o_valid.
        send(5, -5, acc);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        held     = 0;
        exp_prev = 0;
        #1;
        check("abort_valid", int'(o_valid), 0);
        check("abort_angle", int'(o_angle), 0);
        check("abort_dphase", int'(o_dphase), 0);
        check("abort_dir", int'(o_dir), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_ready", int'(o_ready), 1);
        repeat (12) @(negedge clock);
        send(3, -4, acc);
        wait_done();
        check_near("approx_3_m4", int'(o_angle), -9672);

        // Zero vector gives exactly 0 with normal timing.
        send(-2, 2, acc);
        wait_done();
        send(0, 0, acc);
        wait_done();
        check("zero_exact", int'(o_angle), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/cordic_vec_param.md
Name: cordic_vec_param

Overview:
- Parametrised, sequential CORDIC vectoring engine.
- Converts one signed I/Q sample into a phase angle in binary-angle units, where 2^ANG_W LSB = 360°.
- Sits between the baseband I/Q sampler and the O-QPSK phase/chip decision logic.
- Generalises the fixed 4-bit, 6-iteration angle extractor with:
  - configurable widths and iteration count;
  - a valid/ready input handshake;
  - full four-quadrant pre-rotation;
  - arithmetic (sign-correct) shifts.

Parameters:
- IN_W, 4, signed width of i_I and i_Q (range 3..16).
- ANG_W, 16, signed angle width (range 8..16); full circle = 2^ANG_W.
- ITER, 6, number of micro-rotations (range 1..16).
- GUARD, 4, fractional guard bits appended to the internal x/y datapath.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  engine can accept a sample (high only in IDLE).
- i_I  in  IN_W  signed in-phase sample.
- i_Q  in  IN_W  signed quadrature sample.
- o_valid  out  1  single-cycle pulse; o_angle valid.
- o_angle  out  ANG_W  signed phase, held until the next o_valid.
- o_dphase  out  ANG_W  phase difference to the previous result (optional feature; tied 0 when disabled).
- o_dir  out  1  rotation direction (optional feature; tied 0 when disabled).

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; x, y, z and the counter clear.
  - o_valid=0, o_angle=0, o_dphase=0, o_dir=0; o_ready=1 once reset is released.
  - Reset mid-operation aborts the computation with no o_valid.
- Internal widths: x/y are signed with W = IN_W+2+GUARD; z is signed ANG_W, with wrap-around modulo 2^ANG_W.
- FSM states: IDLE, PRE, ROT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready, capture I and Q sign-extended to W and left-shifted by GUARD, then go to PRE.
  - i_valid while not in IDLE is ignored; no buffering.
- PRE (1 cycle), quadrant pre-rotation; "≥0" means the sign bit is clear:
  - I≥0: x=I, y=Q, z=0.
  - I<0 and Q≥0: x=Q, y=-I, z=+quarter (2^(ANG_W-2)).
  - I<0 and Q<0: x=-Q, y=I, z=-quarter.
  - Negating the most-negative input cannot overflow, because W carries 2 extra bits.
  - Then go to ROT with k=0.
- ROT (ITER cycles, k=0..ITER-1):
  - If y≥0: x+=y>>>k, y-=x>>>k, z+=ATAN[k].
  - Otherwise: x-=y>>>k, y+=x>>>k, z-=ATAN[k].
  - All updates use pre-update values; >>> is an arithmetic shift.
  - After k=ITER-1, go to DONE.
- DONE (1 cycle):
  - o_angle<=z and o_valid=1 for this cycle only.
  - Go to IDLE.
- Zero input: I=Q=0 forces o_angle=0, while still following normal timing.
- Latency: o_valid asserts exactly ITER+2 cycles after the accept edge.
- Throughput: one sample per ITER+3 cycles.
- Accuracy: |error| ≤ ATAN[ITER-1] + 2 LSB, apart from quantisation from small IN_W.
- ±180° is represented as -2^(ANG_W-1).

Optional Feature:
- Macro: CORDIC_DPHASE_EN.
- Defined:
  - The block holds the previous o_angle in a register (reset value 0).
  - In DONE: o_dphase <= z - prev (mod 2^ANG_W), and prev <= z.
  - o_dir <= 1 iff o_dphase would be >0 (sign bit clear and nonzero), i.e. counter-clockwise chip transition.
  - Both outputs update with o_valid and hold otherwise.
- Undefined:
  - o_dphase and o_dir are constant 0.
  - No prev register is synthesised.

Decomposition:
- Package cordic_pkg contains:
  - ATAN16[0:15] as 16-bit binary-angle constants: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
  - A function atan_scaled(k, ANG_W) returning ATAN16[k] rounded and shifted right by (16-ANG_W).
  - The state enum typedef cordic_state_t {IDLE, PRE, ROT, DONE}.
- One natural sub-module: cordic_vec_stage, a combinational single micro-rotation (x, y, z, k → x', y', z'), reusable by a future unrolled pipeline.

Test Plan (defaults IN_W=4, ANG_W=16, ITER=6; tolerance ±400 LSB):
- Quadrant points:
  - I=7, Q=0 → o_angle≈0.
  - I=0, Q=7 → ≈16384.
  - I=0, Q=-8 → ≈-16384.
  - I=-8, Q=0 → ≈-32768 (or 32767 wrap).
- Diagonals:
  - I=5, Q=5 → ≈8192.
  - I=-5, Q=-5 → ≈-24576.
  - I=-5, Q=5 → ≈24576.
- Handshake: pulse i_valid with I=3, Q=3 → o_ready falls next cycle and o_valid pulses exactly 8 cycles after accept. A second i_valid during busy is ignored, and o_angle is unchanged by it.
- Reset mid-operation: assert reset_n=0 at cycle 4 after accept → all outputs 0 immediately, no o_valid, o_ready=1 after release; the next sample computes correctly.
- Zero input: I=0, Q=0 → o_angle=0 exactly, o_valid after 8 cycles.
- With CORDIC_DPHASE_EN: sample I=0, Q=7 then I=-5, Q=-5 → second result gives o_dphase≈24576 and o_dir=1. Reversing the order gives ≈-24576 and o_dir=0.
